// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder.
package adder_pkg;

   localparam int unsigned ADDER_WIDTH_MIN = 2;
   localparam int unsigned ADDER_WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } adder_state_e;

endpackage

// File: rtl/fulladder.sv
// One-bit full adder cell.
module fulladder (
   output logic s,
   output logic c,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign s = a ^ b ^ cin;
   assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first through one fulladder cell, with valid/ready in and out.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   generate
      if (WIDTH < ADDER_WIDTH_MIN || WIDTH > ADDER_WIDTH_MAX) begin : g_width_chk
         $error("serial_adder: WIDTH %0d outside supported range", WIDTH);
      end
   endgenerate

   adder_state_e     state;
   adder_state_e     state_next;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             fa_s;
   logic             fa_c;
   logic             accept_c;
   logic             last_c;

   fulladder u_fa (
      .s   (fa_s),
      .c   (fa_c),
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry)
   );

   // Next-state decode; accept and last-bit strobes steer the datapath.
   always_comb begin
      state_next = state;
      accept_c   = 1'b0;
      last_c     = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               accept_c   = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last_c     = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Handshake flags are registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_next;
         in_ready  <= (state_next == ST_IDLE);
         out_valid <= (state_next == ST_DONE);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         if (accept_c) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
         end else if (state == ST_RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            carry  <= fa_c;
            cnt    <= cnt + CNT_W'(1);
         end
         // Result takes the final bit directly so it lands on the same edge as DONE.
         if (last_c) begin
            sum  <= {fa_s, sum_sr[WIDTH-1:1]};
            cout <= fa_c;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // On the MSB cycle the carry register holds the carry into the MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if (last_c) begin
         ovf <= carry ^ fa_c;
      end
   end
`endif

endmodule
